// File: rtl/mult_sequencer.sv
// Control sequencer for the shift-add signed multiplier datapath.
// Latency: Run sampled in IDLE -> done after 1 + 2*WIDTH cycles (1 + WIDTH + popcount(B) with zero-add skip).
// Backpressure: none; a started multiply always completes, DONE holds until Run drops.
//
// Optional build macro: MULT_SKIP_ZERO_ADD_EN skips the ADD cycle for zero multiplier bits
// and adds the B1 input (B register bit 1, i.e. the multiplier LSB after the next shift).
//
// Ports:
//   Clk, Reset        - rising-edge clock, asynchronous active-high reset
//   Run               - level request to start a multiply (held Run never retriggers)
//   ClearA_LoadB      - level request, while idle, to load B and clear A/X
//   M                 - current LSB of the B register
//   B1                - bit 1 of the B register (skip build only)
//   mode              - router select: 00 clear all, 01 clear A/X, 10 add, 11 subtract
//   ld_a, ld_x, ld_b  - register load strobes
//   shift_en          - arithmetic shift of X:A:B right by one
//   busy, done        - sequence in progress / product ready
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic       M,
`ifdef MULT_SKIP_ZERO_ADD_EN
  input  logic       B1,
`endif
  output logic [1:0] mode,
  output logic       ld_a,
  output logic       ld_x,
  output logic       ld_b,
  output logic       shift_en,
  output logic       busy,
  output logic       done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADB,
    S_CLRA,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    mode      = 2'b00;
    ld_a      = 1'b0;
    ld_x      = 1'b0;
    ld_b      = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        // Run wins over a simultaneous load request.
        if (Run)               state_nxt = S_CLRA;
        else if (ClearA_LoadB) state_nxt = S_LOADB;
      end

      S_LOADB: begin
        mode      = 2'b01;
        ld_a      = 1'b1;
        ld_x      = 1'b1;
        ld_b      = 1'b1;
        state_nxt = S_IDLE;
      end

      S_CLRA: begin
        mode      = 2'b01;
        ld_a      = 1'b1;
        ld_x      = 1'b1;
        busy      = 1'b1;
        count_nxt = '0;
`ifdef MULT_SKIP_ZERO_ADD_EN
        state_nxt = M ? S_ADD : S_SHIFT;
`else
        state_nxt = S_ADD;
`endif
      end

      S_ADD: begin
        // Only the final multiplier bit carries negative weight, so it subtracts.
        busy      = 1'b1;
        mode      = (M && (count == LAST)) ? 2'b11 : 2'b10;
        ld_a      = M;
        ld_x      = M;
        state_nxt = S_SHIFT;
      end

      S_SHIFT: begin
        busy     = 1'b1;
        mode     = 2'b10;
        shift_en = 1'b1;
        // Compare before incrementing so the counter never wraps.
        if (count == LAST) begin
          state_nxt = S_DONE;
        end else begin
          count_nxt = count + CW'(1);
`ifdef MULT_SKIP_ZERO_ADD_EN
          // B1 becomes M once this shift lands.
          state_nxt = B1 ? S_ADD : S_SHIFT;
`else
          state_nxt = S_ADD;
`endif
        end
      end

      S_DONE: begin
        mode = 2'b10;
        done = 1'b1;
        if (!Run) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: small datapath model closes the M/B1 loop, scoreboard checks strobes.
// Latency: expectations derived per multiplier bit from plain arithmetic on B.
// Backpressure: n/a.
module tb_mult_sequencer;

  localparam int WIDTH = 8;
`ifdef MULT_SKIP_ZERO_ADD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // Output vector packing: {mode[1:0], ld_a, ld_x, ld_b, shift_en, busy, done}
  localparam logic [7:0] V_LOADB = 8'b01_1_1_1_0_0_0;
  localparam logic [7:0] V_CLRA  = 8'b01_1_1_0_0_1_0;
  localparam logic [7:0] V_ADD0  = 8'b10_0_0_0_0_1_0;
  localparam logic [7:0] V_ADDP  = 8'b10_1_1_0_0_1_0;
  localparam logic [7:0] V_SUB   = 8'b11_1_1_0_0_1_0;
  localparam logic [7:0] V_SHIFT = 8'b10_0_0_0_1_1_0;
  localparam logic [7:0] V_DONE  = 8'b10_0_0_0_0_0_1;

  logic       Clk = 1'b0;
  logic       Reset, Run, ClearA_LoadB, M;
  logic [1:0] mode;
  logic       ld_a, ld_x, ld_b, shift_en, busy, done;
`ifdef MULT_SKIP_ZERO_ADD_EN
  logic       B1;
`endif

  always #5 Clk = ~Clk;

  // Datapath model: switches, A, X, B registers.
  logic [7:0] sw, areg, breg;
  logic       xreg;
  logic [8:0] dp_sum, dp_dif;
  assign dp_sum = {areg[7], areg} + {sw[7], sw};
  assign dp_dif = {areg[7], areg} - {sw[7], sw};
  assign M = breg[0];
`ifdef MULT_SKIP_ZERO_ADD_EN
  assign B1 = breg[1];
`endif

  mult_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
`ifdef MULT_SKIP_ZERO_ADD_EN
    .B1           (B1),
`endif
    .mode         (mode),
    .ld_a         (ld_a),
    .ld_x         (ld_x),
    .ld_b         (ld_b),
    .shift_en     (shift_en),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    areg = '0;
    breg = '0;
    xreg = 1'b0;
  end

  always @(posedge Clk) begin
    if (shift_en) begin
      areg <= {xreg, areg[7:1]};
      breg <= {areg[0], breg[7:1]};
    end else begin
      if (ld_a) areg <= (mode == 2'b10) ? dp_sum[7:0] : (mode == 2'b11) ? dp_dif[7:0] : 8'h00;
      if (ld_x) xreg <= (mode == 2'b10) ? dp_sum[8] : (mode == 2'b11) ? dp_dif[8] : 1'b0;
      if (ld_b) breg <= sw;
    end
  end

  logic [7:0] exp_q[$];
  int n_chk = 0, n_err = 0;   // stimulus-side comparisons
  int m_chk = 0, m_err = 0;   // monitor comparisons

  function automatic logic [7:0] obs_now();
    return {mode, ld_a, ld_x, ld_b, shift_en, busy, done};
  endfunction

  // Monitor: every non-idle output cycle must match the next expected vector.
  logic [7:0] mon_obs, mon_exp;
  always @(negedge Clk) begin
    if (!Reset) begin
      mon_obs = obs_now();
      m_chk++;
      if (shift_en && (ld_a || ld_x || ld_b)) begin
        m_err++;
        $display("FAIL strobe_overlap got %b expected no load with shift", mon_obs);
      end
      if (mon_obs != 8'h00) begin
        m_chk++;
        if (exp_q.size() == 0) begin
          m_err++;
          $display("FAIL unexpected_output got %b expected idle 00000000", mon_obs);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_obs != mon_exp) begin
            m_err++;
            $display("FAIL seq_vector got %b expected %b", mon_obs, mon_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", name, got, expv);
    end
  endtask

  // Reference sequence for one multiply of multiplier b; cut = vectors through SHIFT of iteration 4.
  task automatic build_seq(input logic [7:0] b, output int nvec, output int cut);
    nvec = 1;
    cut  = 0;
    exp_q.push_back(V_CLRA);
    for (int i = 0; i < WIDTH; i++) begin
      if (!SKIP || b[i]) begin
        exp_q.push_back(b[i] ? ((i == WIDTH - 1) ? V_SUB : V_ADDP) : V_ADD0);
        nvec++;
      end
      exp_q.push_back(V_SHIFT);
      nvec++;
      if (i == 4) cut = nvec;
    end
  endtask

  task automatic do_loadb(input logic [7:0] b);
    @(negedge Clk);
    sw = b;
    ClearA_LoadB = 1'b1;
    exp_q.push_back(V_LOADB);
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
  endtask

  // kind: 0 plain, 1 Run dropped while busy, 2 ClearA_LoadB raised while busy, 3 both requests from start
  task automatic do_mult(input logic [7:0] b, input logic [7:0] s, input int hold, input int kind);
    int nvec, cut, cyc;
    logic [15:0] pexp;
    do_loadb(b);
    build_seq(b, nvec, cut);
    for (int i = 0; i < ((kind == 1) ? 1 : hold + 1); i++) exp_q.push_back(V_DONE);
    sw = s;
    Run = 1'b1;
    ClearA_LoadB = (kind == 3);
    cyc = 0;
    while (1) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        if (kind == 1) Run = 1'b0;
        if (kind == 2) ClearA_LoadB = 1'b1;
      end
      if (done || cyc >= 80) break;
    end
    chk("latency", cyc - 1, nvec);
    pexp = 16'(int'($signed(s)) * int'($signed(b)));
    chk("product", int'({areg, breg}), int'(pexp));
    if (kind != 1) repeat (hold) @(posedge Clk);
    @(negedge Clk);
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    repeat (2) @(negedge Clk);
    chk("drain", exp_q.size(), 0);
    chk("back_idle", int'(obs_now()), 0);
  endtask

  initial begin
    int nvec, cut;
    Reset = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    sw = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    chk("in_reset", int'(obs_now()), 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) begin
      @(posedge Clk);
      #1;
      chk("reset_idle", int'(obs_now()), 0);
    end

    do_loadb(8'h5A);
    chk("loadb_b", int'(breg), 8'h5A);
    chk("loadb_drain", exp_q.size(), 0);

    do_mult(8'h03, 8'h17, 3, 0);
    do_mult(8'hFF, 8'hFF, 0, 0);
    do_mult(8'h81, 8'hC3, 1, 0);

    // Abort with Reset during the SHIFT of iteration 4.
    do_loadb(8'hB7);
    build_seq(8'hB7, nvec, cut);
    while (exp_q.size() > cut) void'(exp_q.pop_back());
    sw = 8'h29;
    Run = 1'b1;
    repeat (cut) @(negedge Clk);
    #1;
    Reset = 1'b1;
    Run = 1'b0;
    @(posedge Clk);
    #1;
    chk("abort_idle", int'(obs_now()), 0);
    chk("abort_drain", exp_q.size(), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    do_mult(8'hB7, 8'h29, 0, 0);

    for (int i = 0; i < 20; i++)
      do_mult(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", n_chk + m_chk, n_err + m_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Control unit for the 8-bit shift-add signed multiplier datapath.
- Drives the 2-bit mode select of the operand router: 00 = clear all, 01 = clear A/X and keep B, 10 = add, 11 = subtract complement.
- Also drives register load and shift strobes, and counts WIDTH add/shift iterations.
- Issues a subtract on the final iteration when the multiplier sign bit is set.

Parameters:
- WIDTH, 8, number of multiplier bits = number of add/shift iterations; counter width is clog2(WIDTH).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Run  input  1  level request to start a multiply.
- ClearA_LoadB  input  1  level request to load B and clear A/X while idle.
- M  input  1  current LSB of the B register.
- mode  output  2  router mode select.
- ld_a  output  1  load the A register from the adder.
- ld_x  output  1  load the X sign-extension flop.
- ld_b  output  1  load the B register from the external switch bus.
- shift_en  output  1  arithmetic-shift X:A:B right by one.
- busy  output  1  high from CLRA through the last SHIFT.
- done  output  1  high in the DONE state.

Behaviour:
- Reset state is IDLE with count = 0. Reset values of all outputs: mode = 00, ld_a = 0, ld_x = 0, ld_b = 0, shift_en = 0, busy = 0, done = 0.
- Reset asserted mid-operation aborts the sequence immediately: state returns to IDLE and count returns to 0. No strobes are issued while Reset is high.
- State changes and counter updates are registered on the rising edge of Clk.
- Outputs decode from state. The ADD state alone also uses M and count (Mealy).
- States: IDLE, LOADB, CLRA, ADD, SHIFT, DONE.
- IDLE: outputs mode = 00, all strobes 0.
  - Run = 1 -> CLRA.
  - Else ClearA_LoadB = 1 -> LOADB.
  - Run takes priority when both are high.
- LOADB (1 cycle): ld_b = 1, ld_a = 1, ld_x = 1, mode = 01. Next state is IDLE.
  - ClearA_LoadB still high in IDLE re-enters LOADB. This repeat is harmless.
- CLRA (1 cycle): mode = 01, ld_a = 1, ld_x = 1, busy = 1, count <= 0. B is not loaded. Next state is ADD.
- ADD (1 cycle):
  - M = 1 and count < WIDTH-1: mode = 10, ld_a = 1, ld_x = 1.
  - M = 1 and count = WIDTH-1: mode = 11, ld_a = 1, ld_x = 1.
  - M = 0: mode = 10 with ld_a = 0 and ld_x = 0, so A and X are unchanged.
  - Next state is SHIFT.
- SHIFT (1 cycle): shift_en = 1, mode = 10, no loads.
  - count = WIDTH-1 -> DONE.
  - Else count <= count+1 and next state is ADD.
- DONE: done = 1, mode = 10, no strobes. Holds while Run = 1; Run = 0 -> IDLE. A held Run never retriggers a second multiply.
- Latency with the optional feature off: Run sampled high in IDLE, then 1 + 2*WIDTH cycles (17 for WIDTH = 8) until done rises.
- Run deasserted during busy is ignored. The sequence always completes.
- ClearA_LoadB is ignored outside IDLE.
- Count never wraps: it is compared with WIDTH-1 before incrementing.
- shift_en and any ld_* are never high in the same cycle.

Optional Feature:
- Macro: MULT_SKIP_ZERO_ADD_EN.
- Defined: in SHIFT with count < WIDTH-1, the next state is ADD if B[1] = 1 (this is M after the shift).
  - When B[1] = 0, the next state is SHIFT again with count <= count+1, and the ADD cycle is skipped.
  - From CLRA, M = 0 goes directly to SHIFT.
  - This requires an extra input B1 (1 bit) that is present only under the macro.
  - Latency = 1 + WIDTH + popcount(B).
- Not defined: fixed two-cycle iteration as described above, and no B1 port.

Test Plan:
- Reset high for 2 cycles, then released with Run = 0 -> IDLE, mode = 00, all strobes/busy/done = 0 and held.
- IDLE, pulse ClearA_LoadB for 1 cycle -> exactly one cycle of ld_b = ld_a = ld_x = 1 with mode = 01, then IDLE.
- B = 8'h03, Run held high (feature off) -> CLRA, then alternating ADD/SHIFT.
  - Expected ld_a in ADD: 1, 1, 0, 0, 0, 0, 0, 0.
  - done rises exactly 17 cycles after Run is sampled; done holds until Run = 0, with no restart.
- B = 8'hFF -> ADD mode 10 for iterations 0-6 and mode 11 on iteration 7. Datapath product for A = 8'hFF is 16'h0001.
- Reset asserted during the SHIFT of iteration 4 -> the next cycle is IDLE with count = 0 and no strobes. A fresh Run gives full 17-cycle latency.
- MULT_SKIP_ZERO_ADD_EN, B = 8'h81 -> exactly 2 ADD cycles (iteration 0 mode 10, iteration 7 mode 11), done after 1 + 8 + 2 = 11 cycles.
